// File: rtl/program_mem_pkg.sv
// Shared definitions for the loadable instruction memory: NOP encoding and
// the controller state type, also used by the fetch stage and the testbench.
package program_mem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/program_mem_if.sv
// Loader and fetch/response bundle between the instruction memory and its
// producer (loader) / consumer (core fetch).
interface program_mem_if #(
    parameter int ADDR_W = 32
);

    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_done;
    logic              load_overflow;
    logic              running;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_fault;

    modport master (
        output load_valid, load_data, load_done,
        output fetch_req, fetch_addr, rsp_ready,
        input  load_overflow, running, fetch_ready,
        input  rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  load_valid, load_data, load_done,
        input  fetch_req, fetch_addr, rsp_ready,
        output load_overflow, running, fetch_ready,
        output rsp_valid, rsp_data, rsp_fault
    );

endinterface

// File: rtl/program_mem_array.sv
// DEPTH x WIDTH simple dual-port RAM: one synchronous write port, one
// synchronous read port, no reset so it maps onto block RAM.
module program_mem_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only updates on enable so a stalled response stays put.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/program_mem.sv
// Loadable instruction memory: sequential image load after reset, then
// one-cycle fetches; unloaded or faulting addresses return NOP.
module program_mem
    import program_mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    program_mem_if.slave mem_bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_load_cnt;
    logic              r_overflow;
    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic              r_rsp_fault;

    logic              w_full;
    logic              w_load_we;
    logic [ADDR_W-1:0] w_offset;
    logic [IDX_W-1:0]  w_idx;
    logic              w_fault;
    logic              w_hit;
    logic              w_fetch_ready;
    logic              w_accept;
    logic [31:0]       w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    if (mem_bus.load_done) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = LOAD;
        endcase
    end

    // DEPTH is a power of two, so the counter MSB alone marks a full image.
    assign w_full    = r_load_cnt[IDX_W];
    assign w_load_we = (r_state == LOAD) && mem_bus.load_valid && !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == LOAD && mem_bus.load_valid) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
        end
    end

    // BASE_ADDR is word aligned, so the offset's low bits reflect misalignment.
    assign w_offset = mem_bus.fetch_addr - BASE_ADDR;
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_fault  = (w_offset[1:0] != 2'b00)
                   || (mem_bus.fetch_addr < BASE_ADDR)
                   || (w_offset[ADDR_W-1:IDX_W+2] != '0);
    assign w_hit    = !w_fault && ({1'b0, w_idx} < r_load_cnt);

    assign w_fetch_ready = (r_state == RUN) && (!r_rsp_valid || mem_bus.rsp_ready);
    assign w_accept      = mem_bus.fetch_req && w_fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_hit;
            r_rsp_fault <= w_fault;
        end else if (mem_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    program_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_array (
        .clk     (clk),
        .i_we    (w_load_we),
        .i_waddr (r_load_cnt[IDX_W-1:0]),
        .i_wdata (mem_bus.load_data),
        .i_re    (w_accept),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign mem_bus.load_overflow = r_overflow;
    assign mem_bus.running       = (r_state == RUN);
    assign mem_bus.fetch_ready   = w_fetch_ready;
    assign mem_bus.rsp_valid     = r_rsp_valid;
    assign mem_bus.rsp_data      = r_rsp_hit ? w_rdata : NOP_INSTR;
    assign mem_bus.rsp_fault     = r_rsp_fault;

endmodule
